hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Parametrised hazard detection and forwarding controller for the ID stage of the five-stage pipeline. It selects per-operand bypass sources from EX/MEM/WB and never forwards register 0. It generates load-use stalls, including MEM-stage loads when load data is late. It tracks a multi-cycle multiply/divide unit (MDU) with an internal busy counter and keeps a saturating stall-cycle statistic.

## Interface
- ADDR_W, 5, register address width
- NUM_SRC, 2, number of ID source operands checked
- LOAD_FWD_FROM_MEM, 1, 1: load data is forwardable from MEM; 0: a MEM-stage load match also stalls
- MDU_LATENCY, 4, cycles the MDU is busy after an accepted start (0 = never busy)
- CNT_W, 16, stall counter width

- clk, in, 1, clock
- reset_n, in, 1, asynchronous active-low reset
- id_src_addr, in, NUM_SRC*ADDR_W, packed source addresses; operand k at bits [k*ADDR_W +: ADDR_W]
- id_src_used, in, NUM_SRC, operand k is actually read
- ex_destination, mem_destination, wb_destination, in, ADDR_W each, stage destination registers
- ex_rf_enable, mem_rf_enable, wb_rf_enable, in, 1 each, stage writes the register file
- ex_load_instruction, mem_load_instruction, in, 1 each, stage holds a load
- id_mdu_start, in, 1, ID holds mult/div
- id_mdu_read, in, 1, ID holds mfhi/mflo
- stat_clear, in, 1, synchronous clear of stall_count
- fwd_sel, out, 2*NUM_SRC, operand k at [2k+:2]; 00 RF, 01 EX, 10 MEM, 11 WB
- load_enable, out, 1, IF/ID register write enable
- pc_enable, out, 1, PC/NPC write enable
- nop_signal, out, 1, inject bubble into ID/EX
- mdu_busy, out, 1, MDU occupied
- stall_count, out, CNT_W, stall cycles since reset/clear

## Operation
- Operand k is live when id_src_used[k]=1 and its address is nonzero. A non-live operand never matches and never causes a hazard.
- A stage matches operand k when its rf_enable=1 and its destination equals the address.
- Load hazard: a live operand matches EX and ex_load_instruction=1. If LOAD_FWD_FROM_MEM=0, a live operand that matches MEM with mem_load_instruction=1 is also a load hazard.
- MDU hazard: mdu_busy=1 and (id_mdu_start or id_mdu_read).
- stall = load hazard OR MDU hazard.
  - On stall: load_enable=0, pc_enable=0, nop_signal=1, all fwd_sel=00.
  - Otherwise: load_enable=1, pc_enable=1, nop_signal=0.
- Forwarding, when not stalled, is resolved per operand by priority EX > MEM > WB > RF (01/10/11/00).
- MDU FSM:
  - IDLE: an accepted start (id_mdu_start=1, stall=0) loads cnt=MDU_LATENCY and moves to BUSY if MDU_LATENCY>0; otherwise it stays in IDLE.
  - BUSY: cnt decrements each cycle; when cnt==1 the next state is IDLE with cnt=0.
  - mdu_busy = (state==BUSY).
  - A start is not accepted while stalled for any reason.
- stall_count:
  - Increments in every cycle with stall=1 and saturates at all-ones.
  - stat_clear=1 sets it to 0, with priority over increment in the same cycle.

## Timing
- fwd_sel, load_enable, pc_enable and nop_signal are combinational from the current inputs and the registered MDU state. Zero-cycle latency.
- mdu_busy and stall_count are registered.
- Accepted start at cycle T: mdu_busy=1 in cycles T+1 through T+MDU_LATENCY, and 0 in cycle T+MDU_LATENCY+1.
- An id_mdu_read at T+MDU_LATENCY+1 does not stall.
- Reset asserted: state IDLE, cnt=0, mdu_busy=0, stall_count=0.
  - With idle inputs the combinational outputs are fwd_sel=0, load_enable=1, pc_enable=1, nop_signal=0.
  - Reset mid-BUSY clears busy immediately, asynchronously.
- Simultaneous load hazard and MDU hazard: a single stall; stall_count increments by 1.
- The same address present in EX, MEM and WB: EX is selected.

## Test plan
- Forwarding priority:
  - rs=3 with EX dest=3 (rf_en=1, non-load) and MEM dest=3 -> fwd_sel[1:0]=01, no stall.
  - rt=7 with only WB dest=7 -> fwd_sel[3:2]=11.
- Register zero: rs=0, EX dest=0, ex_rf_enable=1, ex_load=1 -> fwd_sel=00, no stall.
- Load-use:
  - EX load dest=4, rt=4 -> pc_enable=0, load_enable=0, nop_signal=1, fwd_sel=00, stall_count +1.
  - Next cycle, with the load in MEM: LOAD_FWD_FROM_MEM=1 -> fwd_sel[3:2]=10, no stall; LOAD_FWD_FROM_MEM=0 -> stall again.
- MDU, MDU_LATENCY=4:
  - Start accepted at T -> mdu_busy=1 for T+1..T+4.
  - id_mdu_read at T+2 stalls and stall_count counts; read at T+5 passes.
  - A second start at T+3 stalls and is not accepted.
- Saturation and clear:
  - CNT_W=4, 20 stall cycles -> stall_count=15.
  - stat_clear during a stall -> stall_count=0 the next cycle.
- Asynchronous reset while mdu_busy=1 and stall_count=9 -> both 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - ID-stage hazard detection, operand forwarding and MDU occupancy tracking
module hazard_forward_ctrl #(
    parameter int ADDR_W            = 5,
    parameter int NUM_SRC           = 2,
    parameter int LOAD_FWD_FROM_MEM = 1,
    parameter int MDU_LATENCY       = 4,
    parameter int CNT_W             = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [ADDR_W-1:0]           ex_destination,
    input  logic [ADDR_W-1:0]           mem_destination,
    input  logic [ADDR_W-1:0]           wb_destination,
    input  logic                        ex_rf_enable,
    input  logic                        mem_rf_enable,
    input  logic                        wb_rf_enable,
    input  logic                        ex_load_instruction,
    input  logic                        mem_load_instruction,
    input  logic                        id_mdu_start,
    input  logic                        id_mdu_read,
    input  logic                        stat_clear,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        load_enable,
    output logic                        pc_enable,
    output logic                        nop_signal,
    output logic                        mdu_busy,
    output logic [CNT_W-1:0]            stall_count
);

    localparam int LAT_W = (MDU_LATENCY < 1) ? 1 : $clog2(MDU_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_VAL = LAT_W'(MDU_LATENCY);
    localparam logic LOAD_STALL_IN_MEM = (LOAD_FWD_FROM_MEM == 0);

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    mdu_state_t         state, state_next;
    logic [LAT_W-1:0]   cnt, cnt_next;

    logic [NUM_SRC-1:0] live, ex_hit, mem_hit, wb_hit;
    logic               load_hazard, mdu_hazard, stall;

    // Register 0 is hardwired, so a zero address is never live and never matches.
    always_comb begin
        live    = '0;
        ex_hit  = '0;
        mem_hit = '0;
        wb_hit  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            live[k]    = id_src_used[k] && (id_src_addr[k*ADDR_W +: ADDR_W] != '0);
            ex_hit[k]  = live[k] && ex_rf_enable  && (ex_destination  == id_src_addr[k*ADDR_W +: ADDR_W]);
            mem_hit[k] = live[k] && mem_rf_enable && (mem_destination == id_src_addr[k*ADDR_W +: ADDR_W]);
            wb_hit[k]  = live[k] && wb_rf_enable  && (wb_destination  == id_src_addr[k*ADDR_W +: ADDR_W]);
        end
    end

    assign load_hazard = ((|ex_hit) && ex_load_instruction) ||
                         (LOAD_STALL_IN_MEM && (|mem_hit) && mem_load_instruction);
    assign mdu_hazard  = mdu_busy && (id_mdu_start || id_mdu_read);
    assign stall       = load_hazard || mdu_hazard;

    assign load_enable = !stall;
    assign pc_enable   = !stall;
    assign nop_signal  = stall;

    always_comb begin
        fwd_sel = '0;
        if (!stall) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (ex_hit[k])       fwd_sel[2*k +: 2] = 2'b01;
                else if (mem_hit[k]) fwd_sel[2*k +: 2] = 2'b10;
                else if (wb_hit[k])  fwd_sel[2*k +: 2] = 2'b11;
                else                 fwd_sel[2*k +: 2] = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A stalled start stays in ID and is re-presented, so it must not launch the unit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (id_mdu_start && !stall && (MDU_LATENCY > 0)) begin
                    state_next = BUSY;
                    cnt_next   = LAT_VAL;
                end
            end
            BUSY: begin
                if (cnt == LAT_W'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - LAT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign mdu_busy = (state == BUSY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stat_clear) begin
            stall_count <= '0;
        end else if (stall && !(&stall_count)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - self-checking bench for hazard_forward_ctrl (two parameter sets)
module tb_hazard_forward_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [9:0] src_addr;
    logic [1:0] src_used;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       ex_en, mem_en, wb_en, ex_ld, mem_ld;
    logic       mdu_start, mdu_read, stat_clear;

    logic [3:0]  fs_a, fs_b;
    logic        le_a, pe_a, nop_a, busy_a;
    logic        le_b, pe_b, nop_b, busy_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Instance 0: MEM loads forwardable, 16-bit counter. Instance 1: MEM loads stall, 4-bit counter.
    int m_busy_end[2];
    int m_cnt[2];
    int m_max[2] = '{65535, 15};
    bit m_lfm[2] = '{1'b1, 1'b0};

    logic [3:0] act_fs[2];
    logic [2:0] act_ctl[2];
    logic       act_busy[2];
    int         act_cnt[2];

    always_comb begin
        act_fs[0]   = fs_a;
        act_fs[1]   = fs_b;
        act_ctl[0]  = {le_a, pe_a, nop_a};
        act_ctl[1]  = {le_b, pe_b, nop_b};
        act_busy[0] = busy_a;
        act_busy[1] = busy_b;
        act_cnt[0]  = int'(cnt_a);
        act_cnt[1]  = int'(cnt_b);
    end

    hazard_forward_ctrl #(
        .ADDR_W(5), .NUM_SRC(2), .LOAD_FWD_FROM_MEM(1), .MDU_LATENCY(4), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .id_src_addr(src_addr), .id_src_used(src_used),
        .ex_destination(ex_dst), .mem_destination(mem_dst), .wb_destination(wb_dst),
        .ex_rf_enable(ex_en), .mem_rf_enable(mem_en), .wb_rf_enable(wb_en),
        .ex_load_instruction(ex_ld), .mem_load_instruction(mem_ld),
        .id_mdu_start(mdu_start), .id_mdu_read(mdu_read), .stat_clear(stat_clear),
        .fwd_sel(fs_a), .load_enable(le_a), .pc_enable(pe_a), .nop_signal(nop_a),
        .mdu_busy(busy_a), .stall_count(cnt_a)
    );

    hazard_forward_ctrl #(
        .ADDR_W(5), .NUM_SRC(2), .LOAD_FWD_FROM_MEM(0), .MDU_LATENCY(4), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .id_src_addr(src_addr), .id_src_used(src_used),
        .ex_destination(ex_dst), .mem_destination(mem_dst), .wb_destination(wb_dst),
        .ex_rf_enable(ex_en), .mem_rf_enable(mem_en), .wb_rf_enable(wb_en),
        .ex_load_instruction(ex_ld), .mem_load_instruction(mem_ld),
        .id_mdu_start(mdu_start), .id_mdu_read(mdu_read), .stat_clear(stat_clear),
        .fwd_sel(fs_b), .load_enable(le_b), .pc_enable(pe_b), .nop_signal(nop_b),
        .mdu_busy(busy_b), .stall_count(cnt_b)
    );

    // Reference: MDU is busy in the cycles up to busy_end; the rest follows the hazard rules directly.
    function automatic void ref_comb(input int i, output logic [3:0] fs, output bit stall, output bit busy);
        bit         ld;
        logic [1:0] sel[2];
        ld   = 1'b0;
        busy = (cyc <= m_busy_end[i]);
        for (int k = 0; k < 2; k++) begin
            logic [4:0] a;
            bit live, em, mm, wm;
            a    = src_addr[k*5 +: 5];
            live = src_used[k] && (a != 5'd0);
            em   = live && ex_en  && (ex_dst  == a);
            mm   = live && mem_en && (mem_dst == a);
            wm   = live && wb_en  && (wb_dst  == a);
            if (em && ex_ld) ld = 1'b1;
            if (!m_lfm[i] && mm && mem_ld) ld = 1'b1;
            sel[k] = em ? 2'b01 : mm ? 2'b10 : wm ? 2'b11 : 2'b00;
        end
        stall = ld || (busy && (mdu_start || mdu_read));
        fs    = stall ? 4'b0000 : {sel[1], sel[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy_end[i] = -1;
            m_cnt[i]      = 0;
        end
    endtask

    task automatic clear_inputs();
        src_addr = '0; src_used = '0;
        ex_dst = '0; mem_dst = '0; wb_dst = '0;
        ex_en = 0; mem_en = 0; wb_en = 0; ex_ld = 0; mem_ld = 0;
        mdu_start = 0; mdu_read = 0; stat_clear = 0;
    endtask

    task automatic tick();
        bit         st[2];
        bit         acc[2];
        bit         b;
        logic [3:0] f;
        for (int i = 0; i < 2; i++) begin
            ref_comb(i, f, st[i], b);
            acc[i] = mdu_start && !st[i] && !b;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (stat_clear) m_cnt[i] = 0;
            else if (st[i] && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
            if (acc[i]) m_busy_end[i] = cyc + 4;
        end
        cyc = cyc + 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_fs[i] !== 4'b0000 || act_ctl[i] !== 3'b110) begin
                errors++;
                $display("FAIL reset_comb[%0d]: fwd_sel=%b ctl=%b, expected 0000 110", i, act_fs[i], act_ctl[i]);
            end
            checks++;
            if (act_busy[i] !== 1'b0 || act_cnt[i] != 0) begin
                errors++;
                $display("FAIL reset_state[%0d]: busy=%b count=%0d, expected 0 0", i, act_busy[i], act_cnt[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_forward_priority();
        clear_inputs();
        src_used = 2'b11;
        src_addr = {5'd7, 5'd3};
        ex_dst = 5'd3; ex_en = 1;
        mem_dst = 5'd3; mem_en = 1;
        wb_dst = 5'd7; wb_en = 1;
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_fs[i] !== 4'b1101 || act_ctl[i] !== 3'b110) begin
                errors++;
                $display("FAIL fwd_priority[%0d]: fwd_sel=%b ctl=%b, expected 1101 110", i, act_fs[i], act_ctl[i]);
            end
        end
        wb_dst = 5'd3; mem_dst = 5'd7;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_fs[i] !== 4'b1001) begin
                errors++;
                $display("FAIL fwd_ex_over_mem_wb[%0d]: fwd_sel=%b, expected 1001", i, act_fs[i]);
            end
        end
        tick();
    endtask

    task automatic test_reg_zero();
        clear_inputs();
        src_used = 2'b01;
        src_addr = 10'd0;
        ex_dst = 5'd0; ex_en = 1; ex_ld = 1;
        mem_dst = 5'd0; mem_en = 1; mem_ld = 1;
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_fs[i] !== 4'b0000 || act_ctl[i] !== 3'b110) begin
                errors++;
                $display("FAIL reg_zero[%0d]: fwd_sel=%b ctl=%b, expected 0000 110", i, act_fs[i], act_ctl[i]);
            end
        end
        tick();
    endtask

    task automatic test_load_use();
        int base[2];
        clear_inputs();
        base[0] = m_cnt[0];
        base[1] = m_cnt[1];
        src_used = 2'b10;
        src_addr = {5'd4, 5'd0};
        ex_dst = 5'd4; ex_en = 1; ex_ld = 1;
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_fs[i] !== 4'b0000 || act_ctl[i] !== 3'b001) begin
                errors++;
                $display("FAIL load_use_ex[%0d]: fwd_sel=%b ctl=%b, expected 0000 001", i, act_fs[i], act_ctl[i]);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_cnt[i] != base[i] + 1) begin
                errors++;
                $display("FAIL load_use_count[%0d]: count=%0d, expected %0d", i, act_cnt[i], base[i] + 1);
            end
        end
        ex_en = 0; ex_ld = 0;
        mem_dst = 5'd4; mem_en = 1; mem_ld = 1;
        #2;
        checks++;
        if (fs_a !== 4'b1000 || {le_a, pe_a, nop_a} !== 3'b110) begin
            errors++;
            $display("FAIL load_mem_fwd: fwd_sel=%b ctl=%b, expected 1000 110", fs_a, {le_a, pe_a, nop_a});
        end
        checks++;
        if (fs_b !== 4'b0000 || {le_b, pe_b, nop_b} !== 3'b001) begin
            errors++;
            $display("FAIL load_mem_stall: fwd_sel=%b ctl=%b, expected 0000 001", fs_b, {le_b, pe_b, nop_b});
        end
        tick();
        checks++;
        if (int'(cnt_a) != base[0] + 1 || int'(cnt_b) != base[1] + 2) begin
            errors++;
            $display("FAIL load_mem_count: a=%0d b=%0d, expected %0d %0d", cnt_a, cnt_b, base[0] + 1, base[1] + 2);
        end
    endtask

    task automatic test_mdu();
        int base[2];
        clear_inputs();
        mdu_start = 1;
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctl[i] !== 3'b110 || act_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL mdu_start_accept[%0d]: ctl=%b busy=%b, expected 110 0", i, act_ctl[i], act_busy[i]);
            end
        end
        tick();
        mdu_start = 0;
        for (int t = 1; t <= 5; t++) begin
            mdu_read  = (t == 2 || t == 5);
            mdu_start = (t == 3);
            base[0] = m_cnt[0];
            base[1] = m_cnt[1];
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_busy[i] !== (t <= 4) || act_ctl[i] !== ((t == 2 || t == 3) ? 3'b001 : 3'b110)) begin
                    errors++;
                    $display("FAIL mdu_T+%0d[%0d]: busy=%b ctl=%b, expected %b %b", t, i, act_busy[i], act_ctl[i],
                             (t <= 4), ((t == 2 || t == 3) ? 3'b001 : 3'b110));
                end
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_cnt[i] != base[i] + ((t == 2 || t == 3) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL mdu_count_T+%0d[%0d]: count=%0d, expected %0d", t, i, act_cnt[i],
                             base[i] + ((t == 2 || t == 3) ? 1 : 0));
                end
            end
        end
        clear_inputs();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL mdu_no_restart[%0d]: busy=%b, expected 0", i, act_busy[i]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        stat_clear = 1;
        tick();
        stat_clear = 0;
        src_used = 2'b01;
        src_addr = {5'd0, 5'd5};
        ex_dst = 5'd5; ex_en = 1; ex_ld = 1;
        for (int n = 0; n < 20; n++) tick();
        checks++;
        if (cnt_a !== 16'd20 || cnt_b !== 4'd15) begin
            errors++;
            $display("FAIL saturation: a=%0d b=%0d, expected 20 15", cnt_a, cnt_b);
        end
        stat_clear = 1;
        tick();
        checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 4'd0) begin
            errors++;
            $display("FAIL clear_during_stall: a=%0d b=%0d, expected 0 0", cnt_a, cnt_b);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        stat_clear = 1;
        tick();
        stat_clear = 0;
        src_used = 2'b10;
        src_addr = {5'd9, 5'd0};
        ex_dst = 5'd9; ex_en = 1; ex_ld = 1;
        for (int n = 0; n < 9; n++) tick();
        clear_inputs();
        mdu_start = 1;
        tick();
        mdu_start = 0;
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_busy[i] !== 1'b1 || act_cnt[i] != 9) begin
                errors++;
                $display("FAIL pre_reset[%0d]: busy=%b count=%0d, expected 1 9", i, act_busy[i], act_cnt[i]);
            end
        end
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_busy[i] !== 1'b0 || act_cnt[i] != 0 || act_ctl[i] !== 3'b110) begin
                errors++;
                $display("FAIL async_reset[%0d]: busy=%b count=%0d ctl=%b, expected 0 0 110", i, act_busy[i],
                         act_cnt[i], act_ctl[i]);
            end
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] f;
        bit         st, b;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) src_addr[k*5 +: 5] = 5'($urandom_range(0, 7));
            src_used   = 2'($urandom_range(0, 3));
            ex_dst     = 5'($urandom_range(0, 7));
            mem_dst    = 5'($urandom_range(0, 7));
            wb_dst     = 5'($urandom_range(0, 7));
            ex_en      = ($urandom_range(0, 3) != 0);
            mem_en     = ($urandom_range(0, 3) != 0);
            wb_en      = ($urandom_range(0, 3) != 0);
            ex_ld      = ($urandom_range(0, 2) == 0);
            mem_ld     = ($urandom_range(0, 2) == 0);
            mdu_start  = ($urandom_range(0, 3) == 0);
            mdu_read   = ($urandom_range(0, 3) == 0);
            stat_clear = ($urandom_range(0, 29) == 0);
            #2;
            for (int i = 0; i < 2; i++) begin
                ref_comb(i, f, st, b);
                checks++;
                if (act_fs[i] !== f || act_ctl[i] !== (st ? 3'b001 : 3'b110) || act_busy[i] !== b ||
                    act_cnt[i] != m_cnt[i]) begin
                    errors++;
                    $display("FAIL random_%0d[%0d]: fwd=%b ctl=%b busy=%b cnt=%0d, expected %b %b %b %0d", n, i,
                             act_fs[i], act_ctl[i], act_busy[i], act_cnt[i], f, (st ? 3'b001 : 3'b110), b, m_cnt[i]);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forward_priority();
        test_reg_zero();
        test_load_use();
        test_mdu();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
